// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: default operand
// width and the controller state encoding. The bench imports this as well.
package div_pkg;

   // Default operand width in bits.
   localparam int DIV_N_DEFAULT = 4;

   // Controller states: waiting for work, iterating, presenting the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // True for states in which the divider reports itself busy.
   function automatic logic div_state_busy(input div_state_t s);
      return (s == RUN) || (s == DONE);
   endfunction

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and either keep the difference (quotient bit 1) or
// restore the original value (quotient bit 0). Purely combinational.
module div_step
   import div_pkg::*;
#(
   parameter int N = DIV_N_DEFAULT
) (
   input  logic [N:0]   rem,       // partial remainder already shifted left by one
   input  logic [N-1:0] B,         // divisor
   output logic [N-1:0] next_rem,  // remainder after this step
   output logic         q_bit      // quotient bit produced by this step
);

   logic [N:0] diff;

   // Trial subtraction and restore/keep selection.
   // The caller keeps the partial remainder below B (or below 2^(N-1) when
   // B is zero), so the shifted value stays under 2*B and the N+1-bit
   // difference is non-negative exactly when its top bit is clear.
   always_comb begin
      diff     = rem - {1'b0, B};
      q_bit    = ~diff[N];
      next_rem = q_bit ? diff[N-1:0] : rem[N-1:0];
   end

endmodule : div_step

// File: rtl/div_seq.sv
// Sequential unsigned restoring divider. Produces one quotient bit per
// clock, MSB first, with a fixed latency of N RUN cycles plus one DONE
// cycle. Results are held in output registers until the next completion.
module div_seq
   import div_pkg::*;
#(
   parameter int N = DIV_N_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic [N-1:0] Q,
   output logic [N-1:0] R,
   output logic         busy,
   output logic         done,
   output logic         dz
);

   // Iteration counter only needs to hold N-1 down to 0.
   localparam int CW = (N > 2) ? $clog2(N) : 1;

   div_state_t     state_reg;
   div_state_t     state_next;
   logic [CW-1:0]  cnt_reg;
   logic [N-1:0]   rem_reg;     // partial remainder
   logic [N-1:0]   dvd_reg;     // dividend bits shift out, quotient bits shift in
   logic [N-1:0]   b_reg;       // divisor captured at the accepting edge
   logic [N-1:0]   q_reg;
   logic [N-1:0]   r_reg;
   logic           dz_reg;

   logic [N:0]     step_rem;
   logic [N-1:0]   step_next_rem;
   logic           step_q;
   logic           last_iter;

   // Bring the next dividend bit into the bottom of the partial remainder.
   assign step_rem  = {rem_reg, dvd_reg[N-1]};
   assign last_iter = (cnt_reg == '0);

   div_step #(
      .N (N)
   ) u_step (
      .rem      (step_rem),
      .B        (b_reg),
      .next_rem (step_next_rem),
      .q_bit    (step_q)
   );

   // Next-state selection: accept in IDLE, count through RUN, one DONE cycle.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_iter) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Controller state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Working datapath: operand capture in IDLE, one division step per RUN cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
         rem_reg <= '0;
         dvd_reg <= '0;
         b_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  b_reg   <= B;
                  dvd_reg <= A;
                  rem_reg <= '0;
                  cnt_reg <= CW'(N - 1);
               end
            end
            RUN: begin
               rem_reg <= step_next_rem;
               dvd_reg <= {dvd_reg[N-2:0], step_q};
               cnt_reg <= cnt_reg - CW'(1);
            end
            default: begin
            end
         endcase
      end
   end

   // Result registers: loaded on the final iteration so they are valid
   // throughout DONE, then held until the next completion.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_reg  <= '0;
         r_reg  <= '0;
         dz_reg <= 1'b0;
      end else if (state_reg == RUN && last_iter) begin
         q_reg  <= {dvd_reg[N-2:0], step_q};
         r_reg  <= step_next_rem;
         dz_reg <= (b_reg == '0);
      end
   end

   assign Q    = q_reg;
   assign R    = r_reg;
   assign dz   = dz_reg;
   assign busy = div_state_busy(state_reg);
   assign done = (state_reg == DONE);

endmodule : div_seq
